// File: rtl/xgs_pattern_gen_mc.sv
// Multi-lane framed video pattern generator: NUM_LANES pixels per beat, valid/ready handshake,
// sof/eol/eof markers, programmable per-frame pattern and inter-line blanking.
module xgs_pattern_gen_mc #(
  parameter int NUM_LANES = 6,
  parameter int PIX_WIDTH = 12,
  parameter int CNT_WIDTH = 12
) (
  input  logic                           sys_clk,
  input  logic                           sys_reset_n,
  input  logic                           start,
  input  logic                           abort,
  input  logic [1:0]                     cfg_mode,
  input  logic [PIX_WIDTH-1:0]           cfg_const,
  input  logic [CNT_WIDTH-1:0]           cfg_line_beats,
  input  logic [CNT_WIDTH-1:0]           cfg_frame_lines,
  input  logic [CNT_WIDTH-1:0]           cfg_blank_cycles,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [NUM_LANES*PIX_WIDTH-1:0] out_data,
  output logic                           out_sof,
  output logic                           out_eol,
  output logic                           out_eof,
  output logic                           busy,
  output logic [15:0]                    frame_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_HBLANK = 2'd2;

  logic [1:0]                     state_q, state_d;
  logic [CNT_WIDTH-1:0]           beat_q, beat_d;
  logic [CNT_WIDTH-1:0]           line_q, line_d;
  logic [CNT_WIDTH-1:0]           blank_q, blank_d;
  logic [15:0]                    frame_q, frame_d;
  logic                           valid_q, valid_d;
  logic [NUM_LANES*PIX_WIDTH-1:0] data_q;
  logic                           sof_q, eol_q, eof_q;
  logic                           upd;

  logic [1:0]           mode_q;
  logic [PIX_WIDTH-1:0] const_q;
  logic [CNT_WIDTH-1:0] lbm1_q, flm1_q, blankcfg_q;

  logic                 load;
  logic [CNT_WIDTH-1:0] lbm1_in, flm1_in;
  logic [1:0]           cur_mode;
  logic [PIX_WIDTH-1:0] cur_const;
  logic [CNT_WIDTH-1:0] cur_lbm1, cur_flm1;
  logic                 xfer;

  function automatic logic [NUM_LANES*PIX_WIDTH-1:0] pixels(
    input logic [1:0]           mode,
    input logic [PIX_WIDTH-1:0] cst,
    input logic [CNT_WIDTH-1:0] beat,
    input logic [CNT_WIDTH-1:0] line
  );
    logic [NUM_LANES*PIX_WIDTH-1:0] res;
    logic [PIX_WIDTH-1:0]           px;
    res = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      case (mode)
        2'd0:    px = PIX_WIDTH'(32'(beat) * 32'(NUM_LANES) + 32'(i));
        2'd1:    px = cst;
        2'd2:    px = PIX_WIDTH'(line);
        default: px = (beat[0] ^ line[0] ^ 1'(i)) ? cst : '0;
      endcase
      res[i*PIX_WIDTH +: PIX_WIDTH] = px;
    end
    return res;
  endfunction

  // A zero beat/line count behaves as one, so the stored value is the last index.
  assign lbm1_in   = (cfg_line_beats  == '0) ? '0 : cfg_line_beats  - CNT_WIDTH'(1);
  assign flm1_in   = (cfg_frame_lines == '0) ? '0 : cfg_frame_lines - CNT_WIDTH'(1);
  assign load      = (state_q == S_IDLE) && start && !abort;
  assign cur_mode  = load ? cfg_mode  : mode_q;
  assign cur_const = load ? cfg_const : const_q;
  assign cur_lbm1  = load ? lbm1_in   : lbm1_q;
  assign cur_flm1  = load ? flm1_in   : flm1_q;
  assign xfer      = valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    line_d  = line_q;
    blank_d = blank_q;
    frame_d = frame_q;
    valid_d = valid_q;
    upd     = 1'b0;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          state_d = S_ACTIVE;
          beat_d  = '0;
          line_d  = '0;
          valid_d = 1'b1;
          upd     = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (xfer) begin
          if (beat_q == lbm1_q) begin
            beat_d = '0;
            if (line_q == flm1_q) begin
              state_d = S_IDLE;
              valid_d = 1'b0;
              frame_d = frame_q + 16'd1;
            end else begin
              line_d = line_q + CNT_WIDTH'(1);
              if (blankcfg_q != '0) begin
                state_d = S_HBLANK;
                blank_d = blankcfg_q - CNT_WIDTH'(1);
                valid_d = 1'b0;
              end else begin
                upd = 1'b1;
              end
            end
          end else begin
            beat_d = beat_q + CNT_WIDTH'(1);
            upd    = 1'b1;
          end
        end
      end
      S_HBLANK: begin
        if (blank_q == '0) begin
          state_d = S_ACTIVE;
          valid_d = 1'b1;
          upd     = 1'b1;
        end else begin
          blank_d = blank_q - CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
    // Abort wins over start and over the state effect of a beat accepted this cycle.
    if (abort) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      upd     = 1'b0;
      frame_d = frame_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      line_q     <= '0;
      blank_q    <= '0;
      frame_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      eof_q      <= 1'b0;
      mode_q     <= '0;
      const_q    <= '0;
      lbm1_q     <= '0;
      flm1_q     <= '0;
      blankcfg_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      blank_q <= blank_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      if (load) begin
        mode_q     <= cfg_mode;
        const_q    <= cfg_const;
        lbm1_q     <= lbm1_in;
        flm1_q     <= flm1_in;
        blankcfg_q <= cfg_blank_cycles;
      end
      // Output beat only changes when a new beat is presented; stalls hold it.
      if (upd) begin
        data_q <= pixels(cur_mode, cur_const, beat_d, line_d);
        sof_q  <= (beat_d == '0) && (line_d == '0);
        eol_q  <= (beat_d == cur_lbm1);
        eof_q  <= (beat_d == cur_lbm1) && (line_d == cur_flm1);
      end else if (!valid_d) begin
        sof_q <= 1'b0;
        eol_q <= 1'b0;
        eof_q <= 1'b0;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sof   = sof_q;
  assign out_eol   = eol_q;
  assign out_eof   = eof_q;
  assign busy      = (state_q != S_IDLE);
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_xgs_pattern_gen_mc.sv
// Directed bench for xgs_pattern_gen_mc: framing, patterns, blanking, backpressure, abort, reset.
module tb_xgs_pattern_gen_mc;
  localparam int NL = 6;
  localparam int PW = 12;
  localparam int CW = 12;
  localparam int DW = NL * PW;

  logic          sys_clk = 1'b0;
  logic          sys_reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    cfg_mode = '0;
  logic [PW-1:0] cfg_const = '0;
  logic [CW-1:0] cfg_line_beats = '0;
  logic [CW-1:0] cfg_frame_lines = '0;
  logic [CW-1:0] cfg_blank_cycles = '0;
  logic          out_ready = 1'b1;
  logic          out_valid, out_sof, out_eol, out_eof, busy;
  logic [DW-1:0] out_data;
  logic [15:0]   frame_cnt;

  logic          v8, sof8, eol8, eof8, busy8;
  logic [NL*8-1:0] data8;
  logic [15:0]   fc8;

  int n_checks = 0;
  int n_fail = 0;
  int exp_frames = 0;

  xgs_pattern_gen_mc #(.NUM_LANES(NL), .PIX_WIDTH(PW), .CNT_WIDTH(CW)) u_dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .start(start), .abort(abort),
    .cfg_mode(cfg_mode), .cfg_const(cfg_const), .cfg_line_beats(cfg_line_beats),
    .cfg_frame_lines(cfg_frame_lines), .cfg_blank_cycles(cfg_blank_cycles),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof), .busy(busy),
    .frame_cnt(frame_cnt)
  );

  xgs_pattern_gen_mc #(.NUM_LANES(NL), .PIX_WIDTH(8), .CNT_WIDTH(CW)) u_dut8 (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .start(start), .abort(abort),
    .cfg_mode(cfg_mode), .cfg_const(cfg_const[7:0]), .cfg_line_beats(cfg_line_beats),
    .cfg_frame_lines(cfg_frame_lines), .cfg_blank_cycles(cfg_blank_cycles),
    .out_ready(out_ready), .out_valid(v8), .out_data(data8),
    .out_sof(sof8), .out_eol(eol8), .out_eof(eof8), .busy(busy8),
    .frame_cnt(fc8)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] model(input int mode, input int b, input int l, input int c);
    logic [DW-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      case (mode)
        0:       v = (b * NL + i) % 4096;
        1:       v = c;
        2:       v = l % 4096;
        default: v = (((b + l + i) % 2) == 1) ? c : 0;
      endcase
      r[i*PW +: PW] = v[PW-1:0];
    end
    return r;
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    n_checks++;
    if ({out_valid, out_sof, out_eol, out_eof, busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 00000", {out_valid, out_sof, out_eol, out_eof, busy});
    end
    n_checks++;
    if (out_data !== '0 || frame_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_data got data=%h fc=%0d want 0/0", out_data, frame_cnt);
    end
    sys_reset_n = 1'b1;
    tick();
  endtask

  task automatic test_ramp_basic();
    logic [3:0] emk;
    cfg_mode = 2'd0; cfg_line_beats = 12'd4; cfg_frame_lines = 12'd2; cfg_blank_cycles = 12'd0;
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int l = 0; l < 2; l++) begin
      for (int b = 0; b < 4; b++) begin
        emk = {1'b1, (b == 0 && l == 0), (b == 3), (b == 3 && l == 1)};
        n_checks++;
        if ({out_valid, out_sof, out_eol, out_eof} !== emk) begin
          n_fail++; $display("FAIL ramp_markers l%0d b%0d got %b want %b", l, b, {out_valid, out_sof, out_eol, out_eof}, emk);
        end
        n_checks++;
        if (out_data !== model(0, b, l, 0)) begin
          n_fail++; $display("FAIL ramp_data l%0d b%0d got %h want %h", l, b, out_data, model(0, b, l, 0));
        end
        if (l == 0 && b == 3) begin
          n_checks++;
          if (out_data[0 +: PW] !== 12'd18 || out_data[5*PW +: PW] !== 12'd23) begin
            n_fail++; $display("FAIL ramp_beat3 got lane0=%0d lane5=%0d want 18/23", out_data[0 +: PW], out_data[5*PW +: PW]);
          end
        end
        start = (l == 1 && b == 3);
        tick();
      end
    end
    start = 1'b0;
    exp_frames++;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin
      n_fail++; $display("FAIL ramp_end got busy=%b v=%b fc=%0d want 0/0/%0d", busy, out_valid, frame_cnt, exp_frames);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL start_on_eof_ignored got busy=%b v=%b want 0/0", busy, out_valid);
    end
  endtask

  task automatic test_ramp_wrap();
    cfg_mode = 2'd0; cfg_line_beats = 12'd50; cfg_frame_lines = 12'd1; cfg_blank_cycles = 12'd0;
    start = 1'b1; tick(); start = 1'b0;
    for (int b = 0; b < 50; b++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== model(0, b, 0, 0)) begin
        n_fail++; $display("FAIL wrap_data12 b%0d got v=%b %h want %h", b, out_valid, out_data, model(0, b, 0, 0));
      end
      if (b == 42) begin
        n_checks++;
        if (data8[4*8 +: 8] !== 8'h00 || data8[0 +: 8] !== 8'hFC) begin
          n_fail++; $display("FAIL wrap_pix8 got lane4=%h lane0=%h want 00/fc", data8[4*8 +: 8], data8[0 +: 8]);
        end
      end
      tick();
    end
    exp_frames++;
    n_checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin
      n_fail++; $display("FAIL wrap_end got busy=%b fc=%0d want 0/%0d", busy, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_back_pressure();
    int b, l, cyc;
    bit done;
    logic [3:0] emk;
    cfg_mode = 2'd0; cfg_line_beats = 12'd4; cfg_frame_lines = 12'd2; cfg_blank_cycles = 12'd0;
    start = 1'b1; tick(); start = 1'b0;
    b = 0; l = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      emk = {1'b1, (b == 0 && l == 0), (b == 3), (b == 3 && l == 1)};
      n_checks++;
      if ({out_valid, out_sof, out_eol, out_eof} !== emk || out_data !== model(0, b, l, 0)) begin
        n_fail++; $display("FAIL bp_beat cyc%0d l%0d b%0d got %b %h want %b %h", cyc, l, b,
                           {out_valid, out_sof, out_eol, out_eof}, out_data, emk, model(0, b, l, 0));
      end
      out_ready = ($urandom_range(0, 1) == 1);
      if (out_ready) begin
        if (b == 3) begin
          b = 0;
          if (l == 1) done = 1'b1; else l++;
        end else begin
          b++;
        end
      end
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    n_checks++;
    if (!done) begin
      n_fail++; $display("FAIL bp_timeout got %0d cycles want frame done", cyc);
    end
    exp_frames++;
    n_checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin
      n_fail++; $display("FAIL bp_end got busy=%b fc=%0d want 0/%0d", busy, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_blank();
    logic [3:0] emk;
    cfg_mode = 2'd2; cfg_line_beats = 12'd2; cfg_frame_lines = 12'd3; cfg_blank_cycles = 12'd3;
    start = 1'b1; tick(); start = 1'b0;
    for (int l = 0; l < 3; l++) begin
      for (int b = 0; b < 2; b++) begin
        emk = {1'b1, (b == 0 && l == 0), (b == 1), (b == 1 && l == 2)};
        n_checks++;
        if ({out_valid, out_sof, out_eol, out_eof} !== emk || out_data !== model(2, b, l, 0)) begin
          n_fail++; $display("FAIL blank_beat l%0d b%0d got %b %h want %b %h", l, b,
                             {out_valid, out_sof, out_eol, out_eof}, out_data, emk, model(2, b, l, 0));
        end
        tick();
      end
      if (l < 2) begin
        for (int k = 0; k < 3; k++) begin
          n_checks++;
          if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL blank_gap l%0d k%0d got v=%b busy=%b want 0/1", l, k, out_valid, busy);
          end
          tick();
        end
      end
    end
    exp_frames++;
    n_checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin
      n_fail++; $display("FAIL blank_end got busy=%b fc=%0d want 0/%0d", busy, frame_cnt, exp_frames);
    end
    cfg_blank_cycles = 12'd0;
  endtask

  task automatic test_abort();
    logic [3:0] emk;
    cfg_mode = 2'd0; cfg_line_beats = 12'd4; cfg_frame_lines = 12'd3; cfg_blank_cycles = 12'd0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      emk = {1'b1, (k == 0), (k % 4 == 3), 1'b0};
      n_checks++;
      if ({out_valid, out_sof, out_eol, out_eof} !== emk || out_data !== model(0, k % 4, k / 4, 0)) begin
        n_fail++; $display("FAIL abort_pre k%0d got %b %h want %b %h", k,
                           {out_valid, out_sof, out_eol, out_eof}, out_data, emk, model(0, k % 4, k / 4, 0));
      end
      start = (k == 1);
      abort = (k == 6);
      tick();
    end
    start = 1'b0; abort = 1'b0;
    n_checks++;
    if ({out_valid, out_sof, out_eol, out_eof, busy} !== 5'b0 || frame_cnt !== 16'(exp_frames)) begin
      n_fail++; $display("FAIL abort_stop got %b fc=%0d want 00000 fc=%0d",
                         {out_valid, out_sof, out_eol, out_eof, busy}, frame_cnt, exp_frames);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle got v=%b busy=%b want 0/0", out_valid, busy);
    end
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      emk = {1'b1, (k == 0), (k % 4 == 3), (k == 11)};
      n_checks++;
      if ({out_valid, out_sof, out_eol, out_eof} !== emk || out_data !== model(0, k % 4, k / 4, 0)) begin
        n_fail++; $display("FAIL abort_restart k%0d got %b %h want %b %h", k,
                           {out_valid, out_sof, out_eol, out_eof}, out_data, emk, model(0, k % 4, k / 4, 0));
      end
      tick();
    end
    exp_frames++;
    n_checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin
      n_fail++; $display("FAIL abort_fresh_end got busy=%b fc=%0d want 0/%0d", busy, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_checker_min();
    logic [DW-1:0] exp_d;
    exp_d = {12'hABC, 12'h000, 12'hABC, 12'h000, 12'hABC, 12'h000};
    cfg_mode = 2'd3; cfg_const = 12'hABC; cfg_line_beats = 12'd0; cfg_frame_lines = 12'd0;
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if ({out_valid, out_sof, out_eol, out_eof} !== 4'b1111) begin
      n_fail++; $display("FAIL chk_markers got %b want 1111", {out_valid, out_sof, out_eol, out_eof});
    end
    n_checks++;
    if (out_data !== exp_d) begin
      n_fail++; $display("FAIL chk_data got %h want %h", out_data, exp_d);
    end
    tick();
    exp_frames++;
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin
      n_fail++; $display("FAIL chk_end got busy=%b v=%b fc=%0d want 0/0/%0d", busy, out_valid, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_reset_midframe();
    cfg_mode = 2'd0; cfg_line_beats = 12'd10; cfg_frame_lines = 12'd2;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre got v=%b busy=%b want 1/1", out_valid, busy);
    end
    sys_reset_n = 1'b0;
    #2;
    exp_frames = 0;
    n_checks++;
    if ({out_valid, out_sof, out_eol, out_eof, busy} !== 5'b0 || out_data !== '0 || frame_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rstmid_clear got %b data=%h fc=%0d want all 0",
                         {out_valid, out_sof, out_eol, out_eof, busy}, out_data, frame_cnt);
    end
    tick();
    sys_reset_n = 1'b1;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rstmid_noresume got v=%b busy=%b fc=%0d want 0/0/0", out_valid, busy, frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_basic();
    test_ramp_wrap();
    test_back_pressure();
    test_blank();
    test_abort();
    test_checker_min();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xgs_pattern_gen_mc.md
# xgs_pattern_gen_mc

Parametrised multi-lane video pattern generator for XGS Athena validation: produces framed, backpressure-aware pixel beats (NUM_LANES pixels per beat) with start-of-frame / end-of-line / end-of-frame markers. It replaces single-lane fixed-ramp stimulus and drives the sensor-datapath input in block-level and system benches. Configuration is latched at frame start. Per-frame pattern modes and inter-line blanking are programmable.

## Interface
- NUM_LANES, 6, pixels per output beat (1..16)
- PIX_WIDTH, 12, bits per pixel (8..16)
- CNT_WIDTH, 12, width of beat/line/blank counters
- sys_clk  in  1  single clock; all logic on rising edge
- sys_reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin one frame; ignored while busy=1
- abort  in  1  one-cycle pulse: terminate frame, return to IDLE
- cfg_mode  in  2  0 ramp, 1 constant, 2 line-index, 3 checkerboard
- cfg_const  in  PIX_WIDTH  pixel value for mode 1, high value for mode 3
- cfg_line_beats  in  CNT_WIDTH  beats per line; 0 treated as 1
- cfg_frame_lines  in  CNT_WIDTH  lines per frame; 0 treated as 1
- cfg_blank_cycles  in  CNT_WIDTH  idle cycles between lines
- out_ready  in  1  downstream accept
- out_valid  out  1  beat valid
- out_data  out  NUM_LANES*PIX_WIDTH  lane i in bits [i*PIX_WIDTH +: PIX_WIDTH]
- out_sof  out  1  first beat of frame
- out_eol  out  1  last beat of line
- out_eof  out  1  last beat of frame (eol also 1)
- busy  out  1  state != IDLE
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0

## Operation
- States: IDLE, ACTIVE, HBLANK.
- IDLE: start=1 -> latch all cfg_*, clear beat_idx/line_idx, go ACTIVE.
- ACTIVE: out_valid=1. Beat transfers when out_valid & out_ready. On transfer: beat_idx++. Last beat of line (beat_idx = line_beats-1): beat_idx<=0; if last line -> IDLE, frame_cnt++; else line_idx++, go HBLANK if blank_cycles>0, else stay ACTIVE.
- HBLANK: out_valid=0, count blank_cycles cycles, then ACTIVE.
- Backpressure: while out_valid=1 and out_ready=0, out_data and markers hold stable.
- Pixel for lane i, all values mod 2^PIX_WIDTH:
  - ramp: beat_idx*NUM_LANES+i
  - constant: cfg_const
  - line-index: line_idx
  - checkerboard: cfg_const if (beat_idx+line_idx+i) odd, else 0
- Markers: sof = (line_idx=0 & beat_idx=0); eol = last beat of line; eof = eol & last line.
- abort (any state): next cycle IDLE, out_valid=0, frame_cnt unchanged. abort has priority over start and over a same-cycle transfer's state update. Any beat accepted in that cycle counts as delivered.
- start in the same cycle the final beat transfers: ignored; needs a new pulse once IDLE.

## Timing
- Reset values: out_valid=0, out_data=0, out_sof/eol/eof=0, busy=0, frame_cnt=0, state IDLE.
- start at cycle N -> first beat valid at N+1, with sof=1.
- With out_ready=1 and blank=0: one beat per cycle; frame = line_beats*frame_lines cycles.
- blank=B: eol beat at T, next line first beat at T+B+1.
- After the eof transfer at T: busy=0 and frame_cnt updated at T+1.
- All outputs registered; no combinational path from out_ready to out_valid.
- Asserting sys_reset_n low mid-frame clears everything immediately; no partial frame resumes.

## Test plan
- NUM_LANES=6, PIX_WIDTH=12, ramp, line_beats=4, lines=2, blank=0, ready=1 -> 8 contiguous beats. Beat 0 lanes 0..5, beat 3 lanes 18..23, eol on beats 3 and 7, eof on 7, frame_cnt=1.
- Ramp wrap, PIX_WIDTH=8, line_beats=50 -> beat 42 lane 4 = (42*6+4) mod 256 = 0x00.
- Toggle out_ready with a random 50% pattern -> data/markers stable while stalled; output identical to the ready=1 reference sequence.
- blank=3, lines=3 -> exactly 3 valid-low cycles between each eol and the next line's first beat; line-index mode gives 0,1,2.
- abort during line 1 beat 2 -> out_valid=0 next cycle, busy=0, frame_cnt unchanged. start during the frame is ignored; a new start gives a fresh frame with sof.
- Checkerboard, cfg_const=0xABC, line_beats=0, lines=0 -> single beat with sof=eol=eof=1, lanes 0,0xABC,0,... Reset asserted mid-frame -> all outputs 0.
